// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control
//  Purpose  : Multi-cycle sequencer for the snake CPU. Fetches 16-bit
//             instructions, steps register-file operands into the ALU
//             latches, fires the ALU, writes results back and resolves
//             conditional jumps on the registered ALU compare flag.
//  Revision : 1.0  - initial release
// ============================================================================
module cpu_control #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  output logic [3:0]      rf_raddr,
  input  logic [7:0]      rf_rdata,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [7:0]      data_out,
  output logic [2:0]      alu_opcode,
  output logic            c_ain,
  output logic            c_bin,
  output logic            c_alu,
  output logic            c_aout,
  input  logic            alu_flag,
  output logic            halted,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] c_OP_ADDI = 4'h2;
  localparam logic [3:0] c_OP_F    = 4'h6;
  localparam logic [3:0] c_OP_NOP  = 4'h7;
  localparam logic [3:0] c_OP_LDI  = 4'h8;
  localparam logic [3:0] c_OP_JMP  = 4'h9;
  localparam logic [3:0] c_OP_JF   = 4'hA;
  localparam logic [3:0] c_OP_JNF  = 4'hB;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  state_t          r_state, w_next_state;
  logic [PC_W-1:0] r_pc, w_next_pc;
  logic [15:0]     r_ir, w_next_ir;

  // Instruction fields, always taken from the latched instruction register
  logic [3:0]      w_op;
  logic [3:0]      w_rd;
  logic [7:0]      w_imm;
  logic [3:0]      w_rs;
  logic            w_is_alu;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:8];
  assign w_imm    = r_ir[7:0];
  assign w_rs     = r_ir[3:0];
  // Opcodes 0..6 are ALU operations (op[3]=0 and not the NOP code 7)
  assign w_is_alu = (w_op[3] == 1'b0) && (w_op != c_OP_NOP);
  // PC arithmetic wraps naturally modulo 2^PC_W
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_target = PC_W'(w_imm);

  assign pc         = r_pc;
  assign alu_opcode = r_ir[14:12];
  assign state_dbg  = r_state;

  // State, program counter and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC_W'(RESET_PC);
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_ir    <= w_next_ir;
    end
  end

  // Next-state, PC update and per-state strobe/datapath outputs
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ir    = r_ir;
    rf_raddr     = 4'h0;
    rf_we        = 1'b0;
    rf_waddr     = 4'h0;
    data_out     = 8'h00;
    c_ain        = 1'b0;
    c_bin        = 1'b0;
    c_alu        = 1'b0;
    c_aout       = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_next_ir    = instr;
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        w_next_pc = w_pc_inc;
        case (w_op)
          c_OP_JMP: w_next_pc = w_target;
          c_OP_JF:  if (alu_flag)  w_next_pc = w_target;
          c_OP_JNF: if (!alu_flag) w_next_pc = w_target;
          default:  ;
        endcase
        if (w_is_alu || (w_op == c_OP_LDI)) begin
          w_next_state = S_LOAD_A;
        end else if (w_op == c_OP_HALT) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_FETCH;
        end
      end

      S_LOAD_A: begin
        c_ain = 1'b1;
        if (w_op == c_OP_LDI) begin
          // LDI passes the immediate through the A latch straight to writeback
          data_out     = w_imm;
          w_next_state = S_WB;
        end else begin
          rf_raddr     = w_rd;
          data_out     = rf_rdata;
          w_next_state = S_LOAD_B;
        end
      end

      S_LOAD_B: begin
        c_bin = 1'b1;
        if (w_op == c_OP_ADDI) begin
          // Immediate operand; the register file is not read
          data_out = w_imm;
        end else begin
          rf_raddr = w_rs;
          data_out = rf_rdata;
        end
        w_next_state = S_EXEC;
      end

      S_EXEC: begin
        c_alu = 1'b1;
        // Compare only updates the ALU flag; nothing to write back
        w_next_state = (w_op == c_OP_F) ? S_FETCH : S_WB;
      end

      S_WB: begin
        c_aout       = 1'b1;
        rf_we        = 1'b1;
        rf_waddr     = w_rd;
        w_next_state = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control
//  Purpose  : Directed self-checking bench for cpu_control with a small
//             behavioural program ROM, register file and ALU around it.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [3:0]  rf_raddr;
  logic [7:0]  rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  data_out;
  logic [2:0]  alu_opcode;
  logic        c_ain, c_bin, c_alu, c_aout;
  logic        alu_flag;
  logic        halted;
  logic [2:0]  state_dbg;

  int total = 0;
  int fails = 0;
  int we_cnt = 0;
  int we_base;

  logic [15:0] rom [256];
  logic [7:0]  rf  [16];
  logic [7:0]  acc, b_lat;
  logic [2:0]  exp_st [6];
  logic [3:0]  exp_sb [6];

  cpu_control #(.PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .pc         (pc),
    .instr      (instr),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .data_out   (data_out),
    .alu_opcode (alu_opcode),
    .c_ain      (c_ain),
    .c_bin      (c_bin),
    .c_alu      (c_alu),
    .c_aout     (c_aout),
    .alu_flag   (alu_flag),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Combinational ROM and register-file reads
  assign instr    = rom[pc];
  assign rf_rdata = rf[rf_raddr];

  // Register file write port, fed from the ALU output bus
  always @(posedge clk) begin
    if (rf_we === 1'b1) rf[rf_waddr] <= acc;
  end

  // Behavioural ALU: A/B latches, accumulator result, registered compare flag
  always @(posedge clk) begin
    if (reset) begin
      acc      <= 8'h00;
      b_lat    <= 8'h00;
      alu_flag <= 1'b0;
    end else begin
      if (c_ain) acc   <= data_out;
      if (c_bin) b_lat <= data_out;
      if (c_alu) begin
        case (alu_opcode)
          3'd0:    acc      <= acc + b_lat;
          3'd1:    acc      <= acc - b_lat;
          3'd2:    acc      <= acc + b_lat;
          3'd6:    alu_flag <= (acc == b_lat);
          default: ;
        endcase
      end
    end
  end

  // Count register-file writes
  always @(posedge clk) begin
    if (rf_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] strobes();
    return {c_ain, c_bin, c_alu, c_aout};
  endfunction

  initial begin
    reset = 1'b1;
    run   = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    exp_st[0] = 3'd0; exp_sb[0] = 4'b0000;
    exp_st[1] = 3'd1; exp_sb[1] = 4'b0000;
    exp_st[2] = 3'd2; exp_sb[2] = 4'b1000;
    exp_st[3] = 3'd3; exp_sb[3] = 4'b0100;
    exp_st[4] = 3'd4; exp_sb[4] = 4'b0010;
    exp_st[5] = 3'd5; exp_sb[5] = 4'b0001;

    // ---- Program 1: LDI r1,5; LDI r2,3; ADD r1,r2; HALT ----
    clear_rom();
    rom[0] = 16'h8105; rom[1] = 16'h8203; rom[2] = 16'h0102; rom[3] = 16'hF000;
    @(posedge clk); #1;
    do_reset();
    check("reset_state",   state_dbg, 3'd0);
    check("reset_pc",      pc, 8'h00);
    check("reset_strobes", strobes(), 4'b0000);
    check("reset_we",      rf_we, 1'b0);
    check("reset_halted",  halted, 1'b0);
    check("reset_dout",    data_out, 8'h00);
    we_base = we_cnt;
    ticks(8);
    check("ldi_x2_state",  state_dbg, 3'd0);
    check("ldi_x2_pc",     pc, 8'h02);
    check("ldi_x2_we",     we_cnt - we_base, 2);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("add_state_%0d", i), state_dbg, exp_st[i]);
      check($sformatf("add_strobe_%0d", i), strobes(), exp_sb[i]);
      tick();
    end
    check("add_r1",        rf[1], 8'h08);
    check("add_done_pc",   pc, 8'h03);
    ticks(2);
    check("halt_flag",     halted, 1'b1);
    check("halt_state",    state_dbg, 3'd6);
    check("halt_pc",       pc, 8'h04);
    check("prog1_we",      we_cnt - we_base, 3);

    // ---- Program 2: LDI r1,7; LDI r2,7; F r1,r2; JF 0x40 (taken) ----
    clear_rom();
    rom[0] = 16'h8107; rom[1] = 16'h8207; rom[2] = 16'h6102; rom[3] = 16'hA040;
    rom[8'h40] = 16'hF000;
    do_reset();
    we_base = we_cnt;
    ticks(13);
    check("f_latency_pc",  pc, 8'h03);
    check("f_latency_st",  state_dbg, 3'd0);
    check("f_no_we",       we_cnt - we_base, 2);
    check("f_flag_eq",     alu_flag, 1'b1);
    ticks(2);
    check("jf_taken_pc",   pc, 8'h40);

    // ---- Same with r2=6: JF not taken ----
    rom[1] = 16'h8206;
    do_reset();
    ticks(15);
    check("jf_fall_pc",    pc, 8'h04);

    // ---- JNF with flag=1: not taken ----
    rom[1] = 16'h8207; rom[3] = 16'hB010;
    do_reset();
    ticks(15);
    check("jnf_fall_pc",   pc, 8'h04);

    // ---- PC wrap: JMP 0xFF; NOP at 0xFF ----
    clear_rom();
    rom[0] = 16'h90FF;
    do_reset();
    ticks(2);
    check("jmp_pc",        pc, 8'hFF);
    ticks(2);
    check("wrap_pc",       pc, 8'h00);

    // ---- ADDI r3,0x22 with r3=0x10 ----
    clear_rom();
    rom[0] = 16'h8310; rom[1] = 16'h2322; rom[2] = 16'hF000;
    do_reset();
    ticks(6);
    check("addi_la_state", state_dbg, 3'd2);
    check("addi_la_raddr", rf_raddr, 4'h3);
    check("addi_la_dout",  data_out, 8'h10);
    tick();
    check("addi_lb_bin",   c_bin, 1'b1);
    check("addi_lb_dout",  data_out, 8'h22);
    check("addi_lb_raddr", rf_raddr, 4'h0);
    ticks(3);
    check("addi_r3",       rf[3], 8'h32);

    // ---- run=0 holds FETCH; HALT ignores run ----
    clear_rom();
    rom[0] = 16'hF000;
    run = 1'b0;
    do_reset();
    ticks(5);
    check("hold_state",    state_dbg, 3'd0);
    check("hold_pc",       pc, 8'h00);
    run = 1'b1;
    tick();
    check("resume_state",  state_dbg, 3'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      tick();
    end
    check("halt_run_state", state_dbg, 3'd6);
    check("halt_run_pc",    pc, 8'h01);
    run = 1'b1;

    // ---- Reset during EXEC of SUB ----
    clear_rom();
    rom[0] = 16'h8109; rom[1] = 16'h1102;
    do_reset();
    we_base = we_cnt;
    ticks(8);
    check("sub_exec_state", state_dbg, 3'd4);
    check("sub_exec_alu",   c_alu, 1'b1);
    reset = 1'b1;
    tick();
    check("abort_state",    state_dbg, 3'd0);
    check("abort_pc",       pc, 8'h00);
    check("abort_we",       rf_we, 1'b0);
    check("abort_strobes",  strobes(), 4'b0000);
    reset = 1'b0;
    tick();
    check("abort_no_wb",    we_cnt - we_base, 1);
    check("abort_r1",       rf[1], 8'h09);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
`default_nettype wire
